// File: rtl/p_bank_pkg.sv
// Shared constants and helpers for the N-bank buffer selector.
// Bank indices are at most 4 bits wide because NBANK is at most 16.
package p_bank_pkg;

    localparam int NBANK_MAX = 16;

    // Returns the next bank index, wrapping at n rather than at a power of two.
    function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic [4:0] n);
        logic [3:0] res;
        if ({1'b0, idx} == (n - 5'd1)) begin
            res = 4'd0;
        end else begin
            res = idx + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/p_bank_ptr.sv
// Circular bank pointer: advances by one with modulo-NBANK wrap.
// A synchronous clear returns it to bank 0.
module p_bank_ptr
    import p_bank_pkg::*;
#(
    parameter  int NBANK = 2,
    localparam int BW    = $clog2(NBANK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [BW-1:0] idx
);

    logic [BW-1:0] idx_r;

    // Pointer register; clr has priority over adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {BW{1'b0}};
        end else if (clr) begin
            idx_r <= {BW{1'b0}};
        end else if (adv) begin
            idx_r <= BW'(next_idx(4'(idx_r), 5'(NBANK)));
        end else begin
            idx_r <= idx_r;
        end
    end

    assign idx = idx_r;

endmodule

// File: rtl/p_bank_ctrl.sv
// N-bank circular occupancy tracker between the source loader and the compute core.
// Keeps write/read bank pointers, a fill count and sticky misuse flags.
module p_bank_ctrl
    import p_bank_pkg::*;
#(
    parameter  int NBANK = 2,
    localparam int BW    = $clog2(NBANK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          src_fin,
    input  logic          s_fin_in,
    output logic [BW-1:0] wr_bank,
    output logic [BW-1:0] rd_bank,
    output logic [BW:0]   cnt,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf
);

    logic [BW:0] cnt_r;
    logic [BW:0] cnt_nxt_s;
    logic        ovf_r;
    logic        udf_r;
    logic        clr_s;
    logic        full_s;
    logic        empty_s;
    logic        acc_wr_s;
    logic        acc_rd_s;
    logic        ovf_set_s;
    logic        udf_set_s;

    assign clr_s   = ~run;
    assign full_s  = (cnt_r == (BW + 1)'(NBANK));
    assign empty_s = (cnt_r == {(BW + 1){1'b0}});

    // A full bank set still accepts a fill when compute frees a bank on the same edge.
    assign acc_rd_s  = run & s_fin_in & ~empty_s;
    assign acc_wr_s  = run & src_fin & (~full_s | acc_rd_s);
    assign ovf_set_s = run & src_fin & ~acc_wr_s;
    assign udf_set_s = run & s_fin_in & empty_s;

    p_bank_ptr #(.NBANK(NBANK)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .adv   (acc_wr_s),
        .idx   (wr_bank)
    );

    p_bank_ptr #(.NBANK(NBANK)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .adv   (acc_rd_s),
        .idx   (rd_bank)
    );

    // Next occupancy from the accepted events.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({acc_wr_s, acc_rd_s})
            2'b10:   cnt_nxt_s = cnt_r + (BW + 1)'(1);
            2'b01:   cnt_nxt_s = cnt_r - (BW + 1)'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {(BW + 1){1'b0}};
        end else if (clr_s) begin
            cnt_r <= {(BW + 1){1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Sticky misuse flags, cleared only by reset or run low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (clr_s) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | ovf_set_s;
            udf_r <= udf_r | udf_set_s;
        end
    end

    assign cnt   = cnt_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign ovf   = ovf_r;
    assign udf   = udf_r;

endmodule

// File: doc/p_bank_ctrl.md
Name: p_bank_ctrl

Overview:
N-bank generalisation of the ping-pong compute/load selector. Tracks which buffer bank the source side is filling and which bank the compute side is consuming, for NBANK >= 2 banks in a circular order. Maintains an occupancy count, so the source runs ahead of compute by up to NBANK banks. Misuse raises sticky error flags. Sits between the source DMA/loader and the compute core, driving bank-select muxes on both sides.

Parameters:
NBANK, 2, number of buffer banks; legal range 2..16.
BW, $clog2(NBANK), width of bank index; derived, not overridden.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  synchronous enable; low clears all state to reset values on next edge
src_fin  in  1  one-cycle pulse: source has finished filling bank wr_bank
s_fin_in  in  1  one-cycle pulse: compute has finished with bank rd_bank
wr_bank  out  BW  bank the source currently writes
rd_bank  out  BW  bank compute currently reads
cnt  out  BW+1  number of full (filled, unconsumed) banks, 0..NBANK
full  out  1  cnt == NBANK
empty  out  1  cnt == 0; compute must not start when high
ovf  out  1  sticky: src_fin seen while full
udf  out  1  sticky: s_fin_in seen while empty

Behaviour:
- Reset (rst_n low, asynchronous) clears wr_bank, rd_bank, cnt, ovf and udf to 0. Result: full=0, empty=1.
- run low at a clock edge applies the same clear synchronously. run low overrides src_fin and s_fin_in in that cycle.
- All outputs are registered, except full and empty, which decode combinationally from the cnt register. Each event takes effect on the edge where it is sampled, so the new values are visible in the next cycle.
- Accepted src_fin (run=1, src_fin=1, and not full, or s_fin_in accepted in the same cycle):
  - wr_bank advances by 1, wrapping from NBANK-1 to 0.
  - cnt increments.
- Accepted s_fin_in (run=1, s_fin_in=1, not empty):
  - rd_bank advances by 1, same wrap rule.
  - cnt decrements.
- Both events in the same cycle:
  - If not empty: both pointers advance and cnt is unchanged.
  - If full: both are accepted, because compute frees a bank in the same edge. No ovf.
  - If empty: s_fin_in is rejected and udf is set. src_fin is accepted, so wr_bank advances and cnt becomes 1.
- Rejected src_fin when full without a same-cycle accepted s_fin_in: no state change except ovf <= 1.
- Rejected s_fin_in when empty: no state change except udf <= 1.
- ovf and udf clear only on reset or run low.
- Wrap is modulo NBANK, not modulo 2^BW. For non-power-of-2 NBANK (e.g. 3), the index sequence is 0,1,2,0. Index value NBANK is never produced.
- Invariant: wr_bank == (rd_bank + cnt) mod NBANK at all times. The bench checks this every cycle.
- NBANK=2 legacy usage: compute selects rd_bank, source selects wr_bank.
- No internal state machine beyond the pointers and counter. The block is a circular occupancy tracker, and the pointer/count registers are its entire state.

Decomposition:
- Shared package p_bank_pkg holds:
  - the NBANK limit constant (16);
  - the function next_idx(idx, n), which increments with wrap at n.
- One natural sub-module, p_bank_ptr, instanced twice (write and read pointer):
  - inputs: clk, rst_n, clr, adv;
  - output: idx;
  - parameter: NBANK.
- Counter, full/empty decode and error flags live in p_bank_ctrl.

Test Plan:
1. Reset/run clear: hold rst_n low mid-stream with cnt=2 -> all outputs 0 and empty=1 immediately, without a clock. Drop run for one cycle after 3 fills -> next cycle wr_bank=0, rd_bank=0, cnt=0, ovf=0.
2. Fill to full, NBANK=4: 4 src_fin pulses -> wr_bank goes 1,2,3,0, cnt=4, full=1. A 5th src_fin -> ovf=1, wr_bank stays 0, cnt stays 4.
3. Drain with underflow: from cnt=2, 3 s_fin_in pulses -> rd_bank advances twice, cnt=0, empty=1. The third pulse sets udf=1 and rd_bank does not move.
4. Simultaneous events:
   - full, both pulses -> cnt stays 4, both pointers +1, no ovf;
   - empty, both pulses -> cnt=1, wr_bank +1, rd_bank unchanged, udf=1;
   - cnt=2, both pulses -> cnt=2, both pointers +1.
5. Non-power-of-2, NBANK=3: 7 paired fill/consume cycles -> indices follow 0,1,2,0,1,2,0,1. Never 3. Invariant holds every cycle.
6. Legacy NBANK=2: alternate src_fin and s_fin_in over 10 cycles -> rd_bank toggles 0,1,0,... and cnt stays within 0..2. Random pulse soak of 10k cycles -> invariant holds every cycle, and no error flag is set unless the stimulus violates full/empty.
